// File: rtl/imm_encoder.sv
// Instruction assembler: packs decoded RISC-V fields into a 32-bit word after range-checking the immediate.
// Legal words leave through a single output register with a sequential write address; illegal requests are flagged.
module imm_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] addr,
  output logic              err_pulse,
  output logic              err_sticky,
  output logic [ADDR_W:0]   word_cnt
);

  logic              out_valid_reg;
  logic [31:0]       inst_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W-1:0] ptr_reg;
  logic [ADDR_W:0]   cnt_reg;
  logic              err_pulse_reg;
  logic              err_sticky_reg;

  logic [31:0] inst_next;
  logic        legal_next;
  logic        accept;
  logic        i_ok, b_ok, j_ok, u_ok;

  // Sign-extension checks: every bit above the encodable range must match the sign bit.
  assign i_ok = (&imm[31:11]) | ~(|imm[31:11]);
  assign b_ok = ~imm[0] & ((&imm[31:12]) | ~(|imm[31:12]));
  assign j_ok = ~imm[0] & ((&imm[31:20]) | ~(|imm[31:20]));
  assign u_ok = ~(|imm[11:0]);

  always_comb begin
    inst_next  = '0;
    legal_next = 1'b0;
    case (fmt)
      3'd0: begin
        inst_next  = {funct7, rs2, rs1, funct3, rd, opcode};
        legal_next = 1'b1;
      end
      3'd1: begin
        inst_next  = {imm[11:0], rs1, funct3, rd, opcode};
        legal_next = i_ok;
      end
      3'd2: begin
        inst_next  = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        legal_next = i_ok;
      end
      3'd3: begin
        inst_next  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        legal_next = b_ok;
      end
      3'd4: begin
        inst_next  = {imm[31:12], rd, opcode};
        legal_next = u_ok;
      end
      3'd5: begin
        inst_next  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        legal_next = j_ok;
      end
      default: begin
        inst_next  = '0;
        legal_next = 1'b0;
      end
    endcase
  end

  // The output slot frees up in the same cycle it is drained, so accepts run back-to-back.
  assign in_ready = !clr && (!out_valid_reg || out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg  <= 1'b0;
      inst_reg       <= '0;
      addr_reg       <= '0;
      ptr_reg        <= '0;
      cnt_reg        <= '0;
      err_pulse_reg  <= 1'b0;
      err_sticky_reg <= 1'b0;
    end else if (clr) begin
      out_valid_reg  <= 1'b0;
      ptr_reg        <= '0;
      cnt_reg        <= '0;
      err_pulse_reg  <= 1'b0;
      err_sticky_reg <= 1'b0;
    end else begin
      err_pulse_reg <= accept && !legal_next;
      if (accept && !legal_next) begin
        err_sticky_reg <= 1'b1;
      end
      if (accept && legal_next) begin
        out_valid_reg <= 1'b1;
        inst_reg      <= inst_next;
        addr_reg      <= ptr_reg;
        ptr_reg       <= ptr_reg + ADDR_W'(1);
        if (cnt_reg != '1) begin
          cnt_reg <= cnt_reg + (ADDR_W+1)'(1);
        end
      end else if (out_valid_reg && out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid  = out_valid_reg;
  assign inst       = inst_reg;
  assign addr       = addr_reg;
  assign err_pulse  = err_pulse_reg;
  assign err_sticky = err_sticky_reg;
  assign word_cnt   = cnt_reg;

endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder: vector table driven through a negedge scoreboard model,
// plus hand sequences for backpressure, pointer wrap/saturation, clr and async reset.
module tb_imm_encoder;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    bit          legal;
    logic [31:0] inst;
  } vec_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [7:0]  addr;
  } out_t;

  logic        clk = 1'b0;
  logic        rst_n, clr, in_valid, out_ready;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        in_ready, out_valid, err_pulse, err_sticky;
  logic [31:0] inst;
  logic [7:0]  addr;
  logic [8:0]  word_cnt;

  logic        in_valid2, out_ready2;
  logic        in_ready2, out_valid2, err_pulse2, err_sticky2;
  logic [31:0] inst2;
  logic [1:0]  addr2;
  logic [2:0]  word_cnt2;

  int   checks = 0;
  int   errors = 0;
  vec_t vecs[17];
  out_t q[$];
  bit          cur_legal;
  logic [31:0] cur_inst;
  bit          mon_en;
  logic [7:0]  m_ptr;
  int          m_cnt;
  bit          m_err, m_sticky;

  always #5 clk = ~clk;

  imm_encoder #(.ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
    .funct7(funct7), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
    .inst(inst), .addr(addr), .err_pulse(err_pulse), .err_sticky(err_sticky),
    .word_cnt(word_cnt)
  );

  imm_encoder #(.ADDR_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid2), .in_ready(in_ready2),
    .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
    .funct7(funct7), .imm(imm), .out_valid(out_valid2), .out_ready(out_ready2),
    .inst(inst2), .addr(addr2), .err_pulse(err_pulse2), .err_sticky(err_sticky2),
    .word_cnt(word_cnt2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard model: checks current outputs, then advances on the handshakes of the coming edge.
  always @(negedge clk) begin
    bit exp_ready, acc;
    if (!rst_n) begin
      q.delete();
      m_ptr = '0; m_cnt = 0; m_err = 0; m_sticky = 0;
    end else if (mon_en) begin
      exp_ready = !clr && (q.size() == 0 || out_ready);
      chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
      chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
      if (q.size() != 0) begin
        chk("inst", inst, q[0].inst);
        chk("addr", {24'd0, addr}, {24'd0, q[0].addr});
      end
      chk("err_pulse", {31'd0, err_pulse}, {31'd0, m_err});
      chk("err_sticky", {31'd0, err_sticky}, {31'd0, m_sticky});
      chk("word_cnt", {23'd0, word_cnt}, m_cnt);
      acc = in_valid && exp_ready;
      if (clr) begin
        q.delete();
        m_ptr = '0; m_cnt = 0; m_err = 0; m_sticky = 0;
      end else begin
        if (q.size() != 0 && out_ready) begin
          $display("OUT inst=%08h addr=%0d", q[0].inst, q[0].addr);
          void'(q.pop_front());
        end
        m_err = acc && !cur_legal;
        if (acc && !cur_legal) m_sticky = 1;
        if (acc && cur_legal) begin
          q.push_back('{cur_inst, m_ptr});
          m_ptr++;
          if (m_cnt != 511) m_cnt++;
        end
      end
    end
  end

  task automatic set_req(input int i);
    fmt = vecs[i].fmt; opcode = vecs[i].op; rd = vecs[i].rd; rs1 = vecs[i].rs1;
    rs2 = vecs[i].rs2; funct3 = vecs[i].f3; funct7 = vecs[i].f7; imm = vecs[i].imm;
    cur_legal = vecs[i].legal; cur_inst = vecs[i].inst;
    in_valid = 1'b1;
  endtask

  task automatic wait_accept();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 50);
    chk("accept", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    //          fmt   op      rd    rs1   rs2   f3    f7      imm            legal inst
    vecs[0]  = '{3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5,        1'b1, 32'h00500093};
    vecs[1]  = '{3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'd8,        1'b1, 32'h0020A423};
    vecs[2]  = '{3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFC, 1'b1, 32'hFE000EE3};
    vecs[3]  = '{3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000, 1'b1, 32'h123452B7};
    vecs[4]  = '{3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000800, 1'b1, 32'h001000EF};
    vecs[5]  = '{3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048,     1'b0, 32'h0};
    vecs[6]  = '{3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd3,        1'b0, 32'h0};
    vecs[7]  = '{3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00001001, 1'b0, 32'h0};
    vecs[8]  = '{3'd7, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd0,        1'b0, 32'h0};
    vecs[9]  = '{3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hDEADBEEF, 1'b1, 32'h402081B3};
    vecs[10] = '{3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFF800, 1'b1, 32'h80000093};
    vecs[11] = '{3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000FFE, 1'b1, 32'h7E000FE3};
    vecs[12] = '{3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFF00000, 1'b1, 32'h8000006F};
    vecs[13] = '{3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00100000, 1'b0, 32'h0};
    vecs[14] = '{3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'h000007FF, 1'b1, 32'h7E20AFA3};
    vecs[15] = '{3'd6, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd0,        1'b0, 32'h0};
    vecs[16] = '{3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00001000, 1'b0, 32'h0};

    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_valid2 = 1'b0; out_ready2 = 1'b1; mon_en = 1'b0;
    fmt = '0; opcode = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7 = '0; imm = '0;
    cur_legal = 1'b0; cur_inst = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mon_en = 1'b1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_addr", {24'd0, addr}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_word_cnt", {23'd0, word_cnt}, 32'd0);
    chk("rst_err_sticky", {31'd0, err_sticky}, 32'd0);

    // Table: back-to-back with the consumer always ready.
    for (int i = 0; i < 17; i++) begin
      set_req(i);
      wait_accept();
    end
    repeat (2) @(posedge clk);
    #1;

    // Backpressure: hold a word, keep a second request pending, then release.
    out_ready = 1'b0;
    set_req(9);
    wait_accept();
    set_req(10);
    repeat (5) @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_accept();
    repeat (2) @(posedge clk);
    #1;

    // Narrow instance: address wrap and word counter saturation.
    set_req(0);
    in_valid = 1'b0;
    in_valid2 = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      chk("w2_in_ready", {31'd0, in_ready2}, 32'd1);
      if (k > 0) begin
        chk("w2_out_valid", {31'd0, out_valid2}, 32'd1);
        chk("w2_addr", {30'd0, addr2}, (k - 1) % 4);
        chk("w2_inst", inst2, 32'h00500093);
      end
      @(posedge clk);
      #1;
    end
    in_valid2 = 1'b0;
    @(negedge clk);
    chk("w2_last_addr", {30'd0, addr2}, 32'd0);
    chk("w2_word_cnt_sat", {29'd0, word_cnt2}, 32'd7);
    @(posedge clk);
    #1;

    // clr with a pending word, a pending request and the sticky flag set.
    chk("pre_clr_sticky", {31'd0, err_sticky}, 32'd1);
    out_ready = 1'b0;
    set_req(0);
    wait_accept();
    set_req(1);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    chk("clr_out_valid", {31'd0, out_valid}, 32'd0);
    chk("clr_err_sticky", {31'd0, err_sticky}, 32'd0);
    chk("clr_word_cnt", {23'd0, word_cnt}, 32'd0);
    out_ready = 1'b1;
    wait_accept();
    chk("clr_next_addr", {24'd0, addr}, 32'd0);
    chk("clr_next_inst", inst, 32'h0020A423);
    repeat (2) @(posedge clk);
    #1;

    // Asynchronous reset drops a stalled word immediately.
    out_ready = 1'b0;
    set_req(3);
    wait_accept();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_inst", inst, 32'd0);
    chk("arst_word_cnt", {23'd0, word_cnt}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    set_req(4);
    wait_accept();
    chk("arst_next_addr", {24'd0, addr}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("drain", q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_encoder.md
# imm_encoder

Instruction assembler for the FFT program-loading path; the inverse of the core's immediate decoder. It accepts decoded instruction fields over a valid/ready handshake and range-checks the immediate for the selected format. It packs legal requests into a 32-bit RISC-V instruction word and presents it with a sequential instruction-memory write address. Illegal requests are dropped and flagged, so only encodable words reach instruction memory.

## Interface
- ADDR_W, 8, width of the write-address counter (wraps modulo 2^ADDR_W)
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; asynchronous and active-low
- clr  in  1  synchronous clear: address to 0, pending output dropped, sticky error cleared
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- fmt  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6/7 illegal
- opcode  in  7  placed verbatim at inst[6:0]
- rd, rs1, rs2  in  5 each  register fields
- funct3  in  3  funct3 field
- funct7  in  7  funct7 field (R only)
- imm  in  32  byte offset / value, two's complement; U form carries the already-shifted value (low 12 bits zero)
- out_valid  out  1  inst/addr valid
- out_ready  in  1  consumer accepts when out_valid && out_ready
- inst  out  32  assembled instruction
- addr  out  ADDR_W  instruction-memory word address for inst
- err_pulse  out  1  one-cycle pulse: accepted request was dropped
- err_sticky  out  1  set by any err_pulse, cleared by clr only
- word_cnt  out  ADDR_W+1  words emitted since reset/clr, saturating at all-ones

## Operation
- Encodings:
  - R: {funct7, rs2, rs1, funct3, rd, opcode}
  - I: {imm[11:0], rs1, funct3, rd, opcode}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
  - U: {imm[31:12], rd, opcode}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}
- Legality, evaluated at accept:
  - R: always legal; imm ignored.
  - I, S: imm[31:11] all equal (range -2048..2047).
  - B: imm[0]==0 and imm[31:12] all equal (range -4096..4094).
  - J: imm[0]==0 and imm[31:20] all equal.
  - U: imm[11:0]==0.
  - fmt 6/7: illegal.
- Legal accept: the output register loads inst; addr takes the current write pointer; the pointer increments (wraps 2^ADDR_W-1 -> 0); word_cnt increments (saturates).
- Illegal accept: nothing is loaded; pointer and word_cnt are unchanged; err_pulse fires next cycle; err_sticky is set.
- Output buffer is a single register: in_ready = !clr && (!out_valid || out_ready), which gives full throughput under continuous out_ready.
- clr has priority over all events in the same cycle. The input is not accepted, out_valid falls, the pointer and word_cnt go to 0, and err_sticky clears. An error from that cycle is not recorded.

## Timing
- Reset values: out_valid=0, inst=0, addr=0, err_pulse=0, err_sticky=0, word_cnt=0, write pointer=0. in_ready=1 once rst_n is high.
- Latency: a legal accept in cycle N gives out_valid=1 with inst/addr in cycle N+1. An illegal accept in cycle N gives err_pulse in cycle N+1.
- inst and addr are held stable while out_valid && !out_ready.
- Simultaneous output handshake and new legal accept: the register is reloaded and out_valid stays 1, with no bubble.
- Simultaneous output handshake and illegal accept: out_valid falls next cycle.
- Asserting rst_n low mid-transfer drops the pending word immediately (asynchronous).
- Pointer wrap: the word after addr=2^ADDR_W-1 gets addr=0, and no error is raised.

## Test plan
- Reset, then I fmt, opcode 0x13, rd=1, rs1=0, funct3=0, imm=5 -> next cycle inst=0x00500093, addr=0, word_cnt=1.
- Back-to-back requests with out_ready=1, one per cycle:
  - S (sw x2,8(x1)) -> 0x0020A423, addr=1
  - B (beq x0,x0,imm=0xFFFFFFFC) -> 0xFE000EE3, addr=2
  - U (opcode 0x37, rd=5, imm=0x12345000) -> 0x123452B7, addr=3
  - J (opcode 0x6F, rd=1, imm=0x800) -> 0x001000EF, addr=4
  - in_ready stays 1 throughout.
- Illegal requests, each must give err_pulse, err_sticky=1, no out_valid, addr/word_cnt unchanged:
  - I with imm=2048
  - B with imm=3
  - U with imm=0x1001
  - fmt=7
- Backpressure: hold out_ready=0 for 5 cycles after a legal accept -> in_ready=0 and inst/addr stable. Raising out_ready with a new request pending -> handoff and reload in the same cycle.
- ADDR_W=2 instance: emit 5 legal words -> addrs 0,1,2,3,0.
- Assert clr with out_valid=1, in_valid=1 and err_sticky=1 -> next cycle out_valid=0, err_sticky=0, word_cnt=0; the next legal word gets addr=0.
